// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the rv32i pipeline controller
// Data-memory FSM encoding, stage indices and per-condition clock-enable/bubble patterns.
package rv32i_pkg;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_e;

    localparam int STAGE_FETCH     = 0;
    localparam int STAGE_DECODE    = 1;
    localparam int STAGE_EXECUTE   = 2;
    localparam int STAGE_MEMORY    = 3;
    localparam int STAGE_WRITEBACK = 4;
    localparam int NUM_STAGES      = 5;

    typedef enum logic [2:0] {
        COND_NONE,
        COND_FETCH_STALL,
        COND_LOAD_USE,
        COND_FLUSH,
        COND_MEM_STALL,
        COND_TRAP,
        COND_RESET
    } ctrl_cond_e;

    typedef struct packed {
        logic [NUM_STAGES-1:0] ce;
        logic [NUM_STAGES-1:0] bubble;
    } stage_ctrl_t;

    // Bit k of each field belongs to stage k (fetch = bit 0).
    localparam stage_ctrl_t CTRL_RESET       = '{ce: 5'b00000, bubble: 5'b11111};
    localparam stage_ctrl_t CTRL_TRAP        = '{ce: 5'b11111, bubble: 5'b11110};
    localparam stage_ctrl_t CTRL_MEM_STALL   = '{ce: 5'b10000, bubble: 5'b10000};
    localparam stage_ctrl_t CTRL_FLUSH       = '{ce: 5'b11111, bubble: 5'b00110};
    localparam stage_ctrl_t CTRL_LOAD_USE    = '{ce: 5'b11100, bubble: 5'b00100};
    localparam stage_ctrl_t CTRL_FETCH_STALL = '{ce: 5'b11110, bubble: 5'b00010};
    localparam stage_ctrl_t CTRL_RUN         = '{ce: 5'b11111, bubble: 5'b00000};

    function automatic stage_ctrl_t cond_ctrl(input ctrl_cond_e cond);
        stage_ctrl_t ctrl;
        case (cond)
            COND_RESET:       ctrl = CTRL_RESET;
            COND_TRAP:        ctrl = CTRL_TRAP;
            COND_MEM_STALL:   ctrl = CTRL_MEM_STALL;
            COND_FLUSH:       ctrl = CTRL_FLUSH;
            COND_LOAD_USE:    ctrl = CTRL_LOAD_USE;
            COND_FETCH_STALL: ctrl = CTRL_FETCH_STALL;
            default:          ctrl = CTRL_RUN;
        endcase
        return ctrl;
    endfunction

    function automatic logic cond_is_stall(input ctrl_cond_e cond);
        return (cond == COND_MEM_STALL) || (cond == COND_LOAD_USE) ||
               (cond == COND_FETCH_STALL);
    endfunction

endpackage

// File: rtl/rv32i_pipeline_ctrl_if.sv
// rtl/rv32i_pipeline_ctrl_if.sv - data-memory handshake between memory stage and pipeline controller
interface rv32i_pipeline_ctrl_if;
    logic i_dmem_req;
    logic i_dmem_ack;
    logic o_dmem_fault;

    modport master (
        output i_dmem_req,
        output i_dmem_ack,
        input  o_dmem_fault
    );

    modport slave (
        input  i_dmem_req,
        input  i_dmem_ack,
        output o_dmem_fault
    );
endinterface

// File: rtl/rv32i_dmem_watchdog.sv
// rtl/rv32i_dmem_watchdog.sv - outstanding-cycle counter and timeout compare for data-memory accesses
module rv32i_dmem_watchdog #(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_waiting,
    input  logic i_ack,
    output logic o_timeout
);

    logic [7:0] wait_cnt_q;

    // Counts cycles the access has been outstanding, including the request cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_cnt_q <= '0;
        end else if (i_run) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign o_timeout = i_waiting & ~i_ack & (wait_cnt_q == 8'(DMEM_TIMEOUT - 1));

endmodule

// File: rtl/rv32i_pipeline_ctrl.sv
// rtl/rv32i_pipeline_ctrl.sv - hazard/stall/flush controller for a five-stage rv32i pipeline
// Picks the highest-priority pipeline condition and turns it into per-stage enables and bubbles.
module rv32i_pipeline_ctrl
    import rv32i_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fetch_ack,
    input  logic [4:0]            i_dec_rs1_addr,
    input  logic [4:0]            i_dec_rs2_addr,
    input  logic [4:0]            i_ex_rd_addr,
    input  logic                  i_ex_is_load,
    input  logic                  i_ex_flush,
    input  logic                  i_trap,
    rv32i_pipeline_ctrl_if.slave  dmem,
    output logic [4:0]            o_ce,
    output logic [4:0]            o_bubble,
    output logic [31:0]           o_stall_cnt
);

    dmem_state_e state_q;
    dmem_state_e state_d;
    ctrl_cond_e  cond;
    stage_ctrl_t ctrl;
    logic        timeout;
    logic        load_use;
    logic        mem_stall;
    logic        fault_q;
    logic [31:0] stall_cnt_q;

    assign load_use = i_ex_is_load & (i_ex_rd_addr != 5'd0) &
                      ((i_ex_rd_addr == i_dec_rs1_addr) | (i_ex_rd_addr == i_dec_rs2_addr));

    assign mem_stall = ((state_q == DMEM_IDLE) & dmem.i_dmem_req & ~dmem.i_dmem_ack) |
                       ((state_q == DMEM_WAIT) & ~dmem.i_dmem_ack & ~timeout);

    rv32i_dmem_watchdog #(
        .DMEM_TIMEOUT (DMEM_TIMEOUT)
    ) u_dmem_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_run     (state_d == DMEM_WAIT),
        .i_waiting (state_q == DMEM_WAIT),
        .i_ack     (dmem.i_dmem_ack),
        .o_timeout (timeout)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= DMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_trap) begin
            state_d = DMEM_IDLE;
        end else begin
            case (state_q)
                DMEM_IDLE: if (dmem.i_dmem_req && !dmem.i_dmem_ack) state_d = DMEM_WAIT;
                DMEM_WAIT: if (dmem.i_dmem_ack || timeout)          state_d = DMEM_IDLE;
                default:   state_d = DMEM_IDLE;
            endcase
        end
    end

    always_comb begin
        cond = COND_NONE;
        if (!i_rst_n)          cond = COND_RESET;
        else if (i_trap)       cond = COND_TRAP;
        else if (mem_stall)    cond = COND_MEM_STALL;
        else if (i_ex_flush)   cond = COND_FLUSH;
        else if (load_use)     cond = COND_LOAD_USE;
        else if (!i_fetch_ack) cond = COND_FETCH_STALL;
    end

    assign ctrl     = cond_ctrl(cond);
    assign o_ce     = ctrl.ce;
    assign o_bubble = ctrl.bubble;

    // A trap in the timeout cycle aborts the access, so it must not also report a fault.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fault_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            fault_q <= timeout & ~i_trap;
            if (cond_is_stall(cond) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign dmem.o_dmem_fault = fault_q;
    assign o_stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_rv32i_pipeline_ctrl.sv
// tb/tb_rv32i_pipeline_ctrl.sv - self-checking bench for rv32i_pipeline_ctrl
module tb_rv32i_pipeline_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ack;
    logic [4:0]  rs1, rs2, rd;
    logic        is_load, flush, trap;
    logic [4:0]  ce, bub;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    rv32i_pipeline_ctrl_if bus ();

    rv32i_pipeline_ctrl #(.DMEM_TIMEOUT(T)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fetch_ack    (fetch_ack),
        .i_dec_rs1_addr (rs1),
        .i_dec_rs2_addr (rs2),
        .i_ex_rd_addr   (rd),
        .i_ex_is_load   (is_load),
        .i_ex_flush     (flush),
        .i_trap         (trap),
        .dmem           (bus.slave),
        .o_ce           (ce),
        .o_bubble       (bub),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: an access is "outstanding" for m_age cycles; at most T-1 of them stall.
    bit          m_busy  = 0;
    int          m_age   = 0;
    bit          m_fault = 0;
    logic [31:0] m_cnt   = '0;

    typedef struct {
        logic [4:0] ce;
        logic [4:0] bub;
        bit         stall;
        bit         ms;
        bit         to;
    } mexp_t;

    function automatic mexp_t model_eval();
        mexp_t e;
        bit lu;
        e.to = m_busy && !bus.i_dmem_ack && (m_age == T - 1);
        e.ms = !bus.i_dmem_ack && ((m_busy && m_age < T - 1) || (!m_busy && bus.i_dmem_req));
        lu   = is_load && rd != 0 && (rd == rs1 || rd == rs2);
        e.stall = 0;
        if (!rst_n)          begin e.ce = 5'b00000; e.bub = 5'b11111; end
        else if (trap)       begin e.ce = 5'b11111; e.bub = 5'b11110; end
        else if (e.ms)       begin e.ce = 5'b10000; e.bub = 5'b10000; e.stall = 1; end
        else if (flush)      begin e.ce = 5'b11111; e.bub = 5'b00110; end
        else if (lu)         begin e.ce = 5'b11100; e.bub = 5'b00100; e.stall = 1; end
        else if (!fetch_ack) begin e.ce = 5'b11110; e.bub = 5'b00010; e.stall = 1; end
        else                 begin e.ce = 5'b11111; e.bub = 5'b00000; end
        return e;
    endfunction

    task automatic model_update();
        mexp_t e;
        e = model_eval();
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_fault = 0; m_cnt = '0;
        end else begin
            if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (trap)      begin m_busy = 0; m_age = 0; m_fault = 0; end
            else if (e.to) begin m_busy = 0; m_age = 0; m_fault = 1; end
            else if (e.ms) begin m_busy = 1; m_age = m_age + 1; m_fault = 0; end
            else           begin m_busy = 0; m_age = 0; m_fault = 0; end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic neutral();
        rst_n = 1; fetch_ack = 1; rs1 = 0; rs2 = 0; rd = 0;
        is_load = 0; flush = 0; trap = 0;
        bus.i_dmem_req = 0; bus.i_dmem_ack = 0;
    endtask

    task automatic reset_cycle();
        neutral();
        rst_n = 0;
        #1;
        cycle();
        neutral();
    endtask

    typedef struct {
        logic       fa;
        logic [4:0] rs1, rs2, rd;
        logic       ld, fl, tr, req, ack;
        logic [4:0] ce, bub;
    } vec_t;

    vec_t  tbl[12];
    mexp_t e;

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11110, 5'b00010};
        tbl[2]  = '{1, 0, 5, 5, 1, 0, 0, 0, 0, 5'b11100, 5'b00100};
        tbl[3]  = '{0, 7, 1, 7, 1, 0, 0, 0, 0, 5'b11100, 5'b00100};
        tbl[4]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11111, 5'b00000};
        tbl[5]  = '{1, 3, 4, 5, 1, 0, 0, 0, 0, 5'b11111, 5'b00000};
        tbl[6]  = '{1, 0, 5, 5, 0, 0, 0, 0, 0, 5'b11111, 5'b00000};
        tbl[7]  = '{1, 5, 0, 5, 1, 1, 0, 0, 0, 5'b11111, 5'b00110};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 5'b11111, 5'b11110};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 0, 1, 1, 5'b11111, 5'b00110};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 5'b11111, 5'b11110};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11110, 5'b00010};

        neutral();
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("reset_ce", 32'(ce), 32'h00);
        chk("reset_bubble", 32'(bub), 32'h1f);
        cycle();
        #1;
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_fault", 32'(bus.o_dmem_fault), 32'd0);

        // Table vectors, starting from an idle memory FSM.
        neutral();
        for (int i = 0; i < 12; i++) begin
            fetch_ack = tbl[i].fa; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rd = tbl[i].rd;
            is_load = tbl[i].ld; flush = tbl[i].fl; trap = tbl[i].tr;
            bus.i_dmem_req = tbl[i].req; bus.i_dmem_ack = tbl[i].ack;
            #1;
            chk($sformatf("tbl%0d_ce", i), 32'(ce), 32'(tbl[i].ce));
            chk($sformatf("tbl%0d_bubble", i), 32'(bub), 32'(tbl[i].bub));
            cycle();
        end

        // Load-use stall counts one cycle.
        reset_cycle();
        is_load = 1; rd = 5; rs2 = 5;
        #1;
        chk("lu_ce", 32'(ce), 32'h1c);
        cycle();
        neutral();
        #1;
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // Ack after three wait cycles.
        reset_cycle();
        bus.i_dmem_req = 1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("ack3_stall_c%0d", i), 32'(ce), 32'h10);
            cycle();
        end
        bus.i_dmem_ack = 1;
        #1;
        chk("ack3_release_ce", 32'(ce), 32'h1f);
        cycle();
        neutral();
        #1;
        chk("ack3_stall_cnt", stall_cnt, 32'd3);
        chk("ack3_no_fault", 32'(bus.o_dmem_fault), 32'd0);
        chk("ack3_idle_ce", 32'(ce), 32'h1f);

        // Timeout: never acked.
        reset_cycle();
        bus.i_dmem_req = 1;
        for (int i = 1; i <= T - 1; i++) begin
            #1;
            chk($sformatf("to_stall_c%0d", i), 32'(ce), 32'h10);
            cycle();
        end
        #1;
        chk("to_advance_ce", 32'(ce), 32'h1f);
        chk("to_fault_early", 32'(bus.o_dmem_fault), 32'd0);
        cycle();
        bus.i_dmem_req = 0;
        #1;
        chk("to_fault_pulse", 32'(bus.o_dmem_fault), 32'd1);
        chk("to_idle_ce", 32'(ce), 32'h1f);
        chk("to_stall_cnt", stall_cnt, 32'(T - 1));
        cycle();
        #1;
        chk("to_fault_one_cycle", 32'(bus.o_dmem_fault), 32'd0);

        // Trap beats mem stall and flush, and aborts the access.
        reset_cycle();
        bus.i_dmem_req = 1;
        #1;
        cycle();
        trap = 1; flush = 1;
        #1;
        chk("trap_ce", 32'(ce), 32'h1f);
        chk("trap_bubble", 32'(bub), 32'h1e);
        cycle();
        neutral();
        #1;
        chk("trap_idle_ce", 32'(ce), 32'h1f);
        chk("trap_no_fault", 32'(bus.o_dmem_fault), 32'd0);
        cycle();
        #1;
        chk("trap_no_fault_late", 32'(bus.o_dmem_fault), 32'd0);

        // Reset in the middle of a wait.
        reset_cycle();
        bus.i_dmem_req = 1;
        #1;
        cycle(); cycle(); cycle();
        rst_n = 0;
        #1;
        chk("rstwait_ce", 32'(ce), 32'h00);
        chk("rstwait_bubble", 32'(bub), 32'h1f);
        cycle();
        #1;
        chk("rstwait_stall_cnt", stall_cnt, 32'd0);
        chk("rstwait_fault", 32'(bus.o_dmem_fault), 32'd0);
        rst_n = 1; bus.i_dmem_req = 0;
        #1;
        chk("rstwait_idle_ce", 32'(ce), 32'h1f);
        cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(0, 299) != 0);
            trap           = ($urandom_range(0, 29) == 0);
            flush          = ($urandom_range(0, 9) == 0);
            fetch_ack      = ($urandom_range(0, 3) != 0);
            is_load        = $urandom_range(0, 1);
            rd             = 5'($urandom_range(0, 3));
            rs1            = 5'($urandom_range(0, 3));
            rs2            = 5'($urandom_range(0, 3));
            bus.i_dmem_req = ($urandom_range(0, 2) != 0);
            bus.i_dmem_ack = ($urandom_range(0, 7) == 0);
            #1;
            e = model_eval();
            chk("rnd_ce", 32'(ce), 32'(e.ce));
            chk("rnd_bubble", 32'(bub), 32'(e.bub));
            chk("rnd_fault", 32'(bus.o_dmem_fault), 32'(m_fault));
            chk("rnd_stall_cnt", stall_cnt, m_cnt);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
